// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register-hazard scoreboard tracking in-flight writes per register
// Optional same-cycle writeback bypass: define SCOREBOARD_BYPASS_EN.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic        issue_we,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] pending,
  output logic [5:0]  inflight,
  output logic        err_underflow
);

  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam int TW = CNT_W + 5;

  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0]      pending_next;
  logic [TW-1:0]    total;
  logic [TW-1:0]    total_next;
  logic             rs_byp, rt_byp;
  logic             rs_haz, rt_haz, rd_full;
  logic             accept, inc, dec, uflow;
  logic             wb_tracked;

`ifdef SCOREBOARD_BYPASS_EN
  // The register file writes combinationally, so a last outstanding write
  // retiring this cycle already supplies the operand.
  assign rs_byp = (cnt[issue_rs] == ONE) && wb_valid && (wb_rd == issue_rs);
  assign rt_byp = (cnt[issue_rt] == ONE) && wb_valid && (wb_rd == issue_rt);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  assign rs_haz  = issue_use_rs && (issue_rs != 5'd0) && (cnt[issue_rs] != '0) && !rs_byp;
  assign rt_haz  = issue_use_rt && (issue_rt != 5'd0) && (cnt[issue_rt] != '0) && !rt_byp;
  assign rd_full = issue_we && (issue_rd != 5'd0) && (cnt[issue_rd] == MAXC);
  assign stall   = issue_valid && (rs_haz || rt_haz || rd_full);

  assign accept     = issue_valid && !stall;
  assign inc        = accept && issue_we && (issue_rd != 5'd0);
  assign wb_tracked = wb_valid && (wb_rd != 5'd0);
  assign dec        = wb_tracked && (cnt[wb_rd] != '0);
  assign uflow      = wb_tracked && (cnt[wb_rd] == '0);

  always_comb begin
    cnt_next[0]     = '0;
    pending_next    = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_next[i] = cnt[i]
                  + CNT_W'(inc && (issue_rd == 5'(i)))
                  - CNT_W'(dec && (wb_rd == 5'(i)));
      pending_next[i] = (cnt_next[i] != '0);
    end
    total_next = total + TW'(inc) - TW'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      total    <= '0;
      pending  <= '0;
      inflight <= '0;
      if (rst) err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_next[i];
      total    <= total_next;
      pending  <= pending_next;
      inflight <= (total_next > TW'(63)) ? 6'd63 : total_next[5:0];
      if (uflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_we;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic [31:0] pending;
  logic [5:0]  inflight;
  logic        err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: plain integer counts per register
  int m_cnt [32];
  bit m_err;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_we(issue_we), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .pending(pending), .inflight(inflight),
    .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit src_blocked(input int r);
    bit byp;
    byp = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    byp = (m_cnt[r] == 1) && wb_valid && (int'(wb_rd) == r);
`endif
    return (r != 0) && (m_cnt[r] != 0) && !byp;
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    if (issue_use_rs && src_blocked(int'(issue_rs))) return 1'b1;
    if (issue_use_rt && src_blocked(int'(issue_rt))) return 1'b1;
    if (issue_we && issue_rd != 0 && m_cnt[issue_rd] == 3) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of inputs, check stall before the edge and state after it.
  task automatic step(input bit iv, input int rs, input int rt, input bit urs, input bit urt,
                      input bit we, input int rd, input bit wbv, input int wbr,
                      input bit fl, input bit r);
    bit exp_stall;
    int sum;
    logic [31:0] exp_pend;
    @(negedge clk);
    issue_valid = iv; issue_rs = 5'(rs); issue_rt = 5'(rt);
    issue_use_rs = urs; issue_use_rt = urt; issue_we = we; issue_rd = 5'(rd);
    wb_valid = wbv; wb_rd = 5'(wbr); flush = fl; rst = r;
    #1;
    exp_stall = m_stall();
    if (!r) check("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (fl) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (wbv && wbr != 0) begin
        if (m_cnt[wbr] > 0) m_cnt[wbr]--;
        else m_err = 1'b1;
      end
      if (iv && !exp_stall && we && rd != 0) m_cnt[rd]++;
    end
    #1;
    sum = 0;
    exp_pend = '0;
    for (int i = 1; i < 32; i++) begin
      sum += m_cnt[i];
      exp_pend[i] = (m_cnt[i] != 0);
    end
    check("pending", pending, exp_pend);
    check("inflight", 32'(inflight), 32'((sum > 63) ? 63 : sum));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nz [$];
    int wbr;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_pending", pending, 32'h0);
    check("reset_inflight", 32'(inflight), 32'h0);
    check("reset_err", 32'(err_underflow), 32'h0);

    // RAW on r5, released by its writeback
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("raw_pend5", 32'(pending[5]), 32'h1);
    check("raw_inflight", 32'(inflight), 32'h1);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_stall_held", 32'(stall), 32'h1);
    step(1, 5, 0, 1, 0, 0, 0, 1, 5, 0, 0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_released_pend", pending, 32'h0);

    // structural stall on r7 at count 3
    repeat (3) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    check("full7_stall", 32'(stall), 32'h1);
    step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    check("full7_inflight", 32'(inflight), 32'h3);

    // simultaneous inc and dec on r9
    step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0);
    check("same9_pend", 32'(pending[9]), 32'h1);

    // r0 is never tracked
    step(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    check("r0_pend0", 32'(pending[0]), 32'h0);

    // underflow is sticky through flush, cleared by reset
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    check("uflow_set", 32'(err_underflow), 32'h1);
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
    check("flush_inflight", 32'(inflight), 32'h0);
    check("uflow_sticky", 32'(err_underflow), 32'h1);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 1);
    check("rst_flush_err", 32'(err_underflow), 32'h0);

    // randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 4000; c++) begin
      nz.delete();
      for (int i = 1; i < 8; i++) if (m_cnt[i] != 0) nz.push_back(i);
      wbr = (nz.size() != 0 && $urandom_range(9) != 0)
            ? nz[$urandom_range(nz.size() - 1)] : int'($urandom_range(7));
      step($urandom_range(9) < 7, $urandom_range(7), $urandom_range(7),
           $urandom_range(1), $urandom_range(1), $urandom_range(9) < 6,
           $urandom_range(7), $urandom_range(9) < 4, wbr,
           $urandom_range(99) < 2, $urandom_range(199) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard for the stalling pipeline. Sits beside the register file, between the decode stage (issuing reads) and the writeback stage (retiring writes). Tracks in-flight writes per architectural register. Asserts `stall` while a decoding instruction would read a register whose write has not yet retired, or when issuing would overflow a per-register counter.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register in-flight counter; maximum count `MAXC = 2^CNT_W - 1`.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `issue_valid`  in  1: decode stage presents an instruction this cycle.
- `issue_rs`  in  5: first source register address.
- `issue_rt`  in  5: second source register address.
- `issue_use_rs`  in  1: instruction reads `issue_rs`.
- `issue_use_rt`  in  1: instruction reads `issue_rt`.
- `issue_we`  in  1: instruction will write a register.
- `issue_rd`  in  5: destination register address.
- `wb_valid`  in  1: writeback retires a register write this cycle, with the same timing as the register file's `writeEnable`.
- `wb_rd`  in  5: register being written back.
- `flush`  in  1: discard all in-flight writes.
- `stall`  out  1: combinational; decode must hold the instruction.
- `pending`  out  32: registered; bit i = 1 when counter i ≠ 0. Bit 0 is always 0.
- `inflight`  out  6: registered total of all counters, saturating at 63.
- `err_underflow`  out  1: sticky; a writeback arrived for a register with counter 0.

## Operation
- State: 31 counters `cnt[1..31]` of width `CNT_W`. Register 0 is never tracked. All reads, writes and writebacks addressing register 0 are ignored.
- `stall` = `issue_valid` AND any of:
  - `issue_use_rs`, `issue_rs`≠0, `cnt[issue_rs]`≠0.
  - `issue_use_rt`, `issue_rt`≠0, `cnt[issue_rt]`≠0.
  - `issue_we`, `issue_rd`≠0, `cnt[issue_rd]`==MAXC (structural stall).
- Accept = `issue_valid` AND NOT `stall`. On accept with `issue_we` and `issue_rd`≠0: `cnt[issue_rd]` +1.
- Writeback with `wb_valid` and `wb_rd`≠0:
  - If `cnt[wb_rd]`>0, decrement it.
  - Otherwise leave it at 0 and set `err_underflow`.
- Accepted increment and writeback decrement on the same register in the same cycle: the count is unchanged.
- `inflight` tracks the net change each cycle: +1 on an accepted tracked write, -1 on a valid non-underflow writeback.
- `flush`:
  - All counters, `pending` and `inflight` are cleared next cycle.
  - Issue and writeback in the same cycle are ignored.
  - `err_underflow` is unaffected.
  - Upstream guarantees that flushed instructions never raise `wb_valid`.
- `err_underflow` is cleared only by `rst`.

## Timing
- Reset values: all counters 0, `pending`=0, `inflight`=0, `err_underflow`=0. `stall`=0 whenever all counters are 0.
- `rst` has priority over `flush`, which has priority over issue/writeback.
- `stall` is purely combinational from the current counters and the issue inputs. No registered delay.
- Counter updates become visible to `stall` and `pending` in the cycle after the edge.
- Without the bypass option, a source whose writeback occurs in cycle N stalls in cycle N and is released in cycle N+1.
- Reset asserted mid-operation discards all tracking. The bench must not issue `wb_valid` for pre-reset instructions.

## Configuration
- `SCOREBOARD_BYPASS_EN` defined:
  - A source hazard is suppressed when `cnt[src]`==1 and `wb_valid` with `wb_rd`==src in the same cycle. The register file's combinational write makes the value readable that cycle.
  - Hazard is released in cycle N.
  - The structural stall on `issue_rd` is not bypassed.
- Undefined: no suppression. Release happens in cycle N+1 as described under Timing.

## Test plan
- Reset, then issue `rd`=5 with `we` accepted; next cycle issue `use_rs`, `rs`=5 -> `stall`=1, `pending[5]`=1, `inflight`=1. Then `wb_valid`, `wb_rd`=5 -> `stall` drops the following cycle (same cycle with `SCOREBOARD_BYPASS_EN`). `pending`=0.
- Issue three accepted writes to `rd`=7 (`CNT_W`=2); fourth write to 7 -> `stall`=1 from the structural condition with `cnt[7]`=3. One writeback to 7 -> fourth write accepted next cycle, `cnt[7]` stays 3.
- Same cycle: accepted issue `rd`=9 and `wb_valid`, `wb_rd`=9, with `cnt[9]`=1 -> `cnt[9]` stays 1, `inflight` unchanged.
- Writes, reads and writebacks to register 0 -> never stall, `pending`=0, `inflight`=0, `err_underflow`=0.
- `wb_valid`, `wb_rd`=12 with `cnt[12]`=0 -> `err_underflow`=1, sticky through `flush`, cleared by `rst`.
- Two writes in flight to 3 and 4, assert `flush` -> next cycle `pending`=0, `inflight`=0, read of 3 does not stall. `rst` during `flush` -> all outputs 0.
